// File: rtl/spi_reg_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_reg_ctrl_pkg
// Description : Shared constants and types for the SPI register controller:
//               register map, frame length and receiver state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_reg_ctrl_pkg;

    // Frame length in bits: 1 R/W bit, 7 address bits, 8 data bits
    localparam int FRAME_BITS = 16;
    localparam int CNT_W      = $clog2(FRAME_BITS + 1);

    // Register map
    localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
    localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
    localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
    localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
    localparam logic [6:0] ADDR_DUTY      = 7'h04;

    // Receiver state encoding
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/spi_reg_ctrl_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : sync_edge
// Description : Multi-flop synchroniser for an asynchronous input, followed by
//               one history flop that produces single-cycle rise/fall pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic sync_out,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // Synchroniser chain plus one delayed copy for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {SYNC_STAGES{RESET_VAL}};
            r_prev <= RESET_VAL;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], async_in};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign sync_out = r_sync[SYNC_STAGES-1];
    assign rise     =  r_sync[SYNC_STAGES-1] & ~r_prev;
    assign fall     = ~r_sync[SYNC_STAGES-1] &  r_prev;

endmodule
`default_nettype wire

// File: rtl/spi_reg_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : spi_reg_ctrl
// Description : SPI mode-0 write-only register controller. Oversamples the
//               SPI pins in the clk domain, assembles 16-bit frames and
//               commits valid writes into five 8-bit configuration registers.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_reg_ctrl
    import spi_reg_ctrl_pkg::*;
#(
    parameter int MAX_ADDR    = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       wr_strobe
);

    localparam logic [CNT_W-1:0] c_cnt_full = CNT_W'(FRAME_BITS);
    localparam logic [6:0]       c_max_addr = 7'(MAX_ADDR);

    // Synchronised pins and edge pulses
    logic w_sclk_s, w_sclk_rise, w_sclk_fall;
    logic w_ncs_s, w_ncs_rise, w_ncs_fall;
    logic w_copi_s;
    logic [SYNC_STAGES-1:0] r_copi_sync;

    // Receiver state
    state_t                r_state, w_state_nxt;
    logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
    logic [FRAME_BITS-1:0] r_shift, w_shift_nxt;
    logic                  w_commit;
    logic                  w_frame_ok;

    // Configuration registers
    logic [7:0] r_en_out_lo, r_en_out_hi, r_en_pwm_lo, r_en_pwm_hi, r_duty;
    logic       r_wr_strobe;

    sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b0)
    ) u_sync_sclk (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (sclk),
        .sync_out (w_sclk_s),
        .rise     (w_sclk_rise),
        .fall     (w_sclk_fall)
    );

    // ncs idles high, so its synchroniser resets high to avoid a false edge
    sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b1)
    ) u_sync_ncs (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (ncs),
        .sync_out (w_ncs_s),
        .rise     (w_ncs_rise),
        .fall     (w_ncs_fall)
    );

    // Only levels and edges actually consumed by the receiver are used
    logic w_unused_sync;
    assign w_unused_sync = &{1'b0, w_sclk_s, w_sclk_fall, w_ncs_s};

    // Data line needs the level only, no edge history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_copi_sync <= '0;
        end else begin
            r_copi_sync <= {r_copi_sync[SYNC_STAGES-2:0], copi};
        end
    end
    assign w_copi_s = r_copi_sync[SYNC_STAGES-1];

    // A frame is accepted only if it is a full-length write to a mapped address
    assign w_frame_ok = (r_cnt == c_cnt_full) && r_shift[FRAME_BITS-1] &&
                        (r_shift[14:8] <= c_max_addr);

    // Receiver state, bit counter and shift register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_shift <= w_shift_nxt;
        end
    end

    // Next-state logic: frame start, bit capture and frame end evaluation
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shift_nxt = r_shift;
        w_commit    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_ncs_fall) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = '0;
                    w_state_nxt = RECV;
                end
            end
            RECV: begin
                if (w_ncs_rise) begin
                    w_state_nxt = IDLE;
                    w_commit    = w_frame_ok;
                end else if (w_sclk_rise && (r_cnt != c_cnt_full)) begin
                    // Bits beyond the 16th are dropped, keeping the first 16
                    w_shift_nxt = {r_shift[FRAME_BITS-2:0], w_copi_s};
                    w_cnt_nxt   = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Register file update and one-cycle write strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en_out_lo <= 8'h00;
            r_en_out_hi <= 8'h00;
            r_en_pwm_lo <= 8'h00;
            r_en_pwm_hi <= 8'h00;
            r_duty      <= 8'h00;
            r_wr_strobe <= 1'b0;
        end else begin
            r_wr_strobe <= w_commit;
            if (w_commit) begin
                case (r_shift[14:8])
                    ADDR_EN_OUT_LO: r_en_out_lo <= r_shift[7:0];
                    ADDR_EN_OUT_HI: r_en_out_hi <= r_shift[7:0];
                    ADDR_EN_PWM_LO: r_en_pwm_lo <= r_shift[7:0];
                    ADDR_EN_PWM_HI: r_en_pwm_hi <= r_shift[7:0];
                    ADDR_DUTY:      r_duty      <= r_shift[7:0];
                    default: ;
                endcase
            end
        end
    end

    assign en_reg_out_7_0  = r_en_out_lo;
    assign en_reg_out_15_8 = r_en_out_hi;
    assign en_reg_pwm_7_0  = r_en_pwm_lo;
    assign en_reg_pwm_15_8 = r_en_pwm_hi;
    assign pwm_duty_cycle  = r_duty;
    assign wr_strobe       = r_wr_strobe;

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_reg_ctrl
// Description : Self-checking bench for spi_reg_ctrl. Bit-bangs SPI frames
//               and compares the register outputs with a frame-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_reg_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sclk;
    logic       copi;
    logic       ncs;
    logic [7:0] en_reg_out_7_0;
    logic [7:0] en_reg_out_15_8;
    logic [7:0] en_reg_pwm_7_0;
    logic [7:0] en_reg_pwm_15_8;
    logic [7:0] pwm_duty_cycle;
    logic       wr_strobe;

    int errors        = 0;
    int checks        = 0;
    int strobe_cycles = 0;
    int exp_strobes   = 0;

    // Reference register file, indexed by address
    logic [7:0] m_regs [5];

    spi_reg_ctrl #(
        .MAX_ADDR    (4),
        .SYNC_STAGES (2)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .sclk            (sclk),
        .copi            (copi),
        .ncs             (ncs),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle),
        .wr_strobe       (wr_strobe)
    );

    always #5 clk = ~clk;

    // Count every clk cycle with the strobe high; one pulse = one cycle
    always @(posedge clk) begin
        if (wr_strobe === 1'b1) strobe_cycles++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] dut_reg(input int i);
        case (i)
            0:       return en_reg_out_7_0;
            1:       return en_reg_out_15_8;
            2:       return en_reg_pwm_7_0;
            3:       return en_reg_pwm_15_8;
            default: return pwm_duty_cycle;
        endcase
    endfunction

    task automatic check_regs(input string tag);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("%s_reg%0d", tag, i), 32'(dut_reg(i)), 32'(m_regs[i]));
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Shift n bits of v, MSB first; copi changes while sclk is low
    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            copi = v[i];
            wait_clks(4);
            sclk = 1'b1;
            wait_clks(4);
            sclk = 1'b0;
        end
    endtask

    // Complete frame with latency check: registers must still hold the old
    // value two edges after ncs is sampled high and the new value after three
    task automatic send_frame(input logic [31:0] v, input int n, input int gap);
        logic [15:0] f;
        logic        commit;
        f      = 16'h0000;
        commit = 1'b0;
        ncs = 1'b0;
        wait_clks(4);
        send_bits(v, n);
        wait_clks(4);
        if (n >= 16) begin
            f      = 16'(v >> (n - 16));
            commit = f[15] && (int'(f[14:8]) <= 4);
        end
        ncs = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check_regs("pre");
        chk("strobe_pre", 32'(wr_strobe), 32'd0);
        if (commit) begin
            m_regs[f[14:8]] = f[7:0];
            exp_strobes++;
        end
        @(posedge clk);
        @(negedge clk);
        check_regs("post");
        chk("strobe", 32'(wr_strobe), 32'(commit));
        if (gap > 3) wait_clks(gap - 3);
    endtask

    initial begin
        logic [15:0] base;
        logic [31:0] v;
        int          n;

        for (int i = 0; i < 5; i++) m_regs[i] = 8'h00;
        rst_n = 1'b0;
        sclk  = 1'b0;
        copi  = 1'b0;
        ncs   = 1'b1;
        wait_clks(3);
        check_regs("reset");
        chk("reset_strobe", 32'(wr_strobe), 32'd0);
        rst_n = 1'b1;
        wait_clks(4);

        // Directed frames
        send_frame(32'h80F0, 16, 6);
        send_frame(32'h8480, 16, 6);
        send_frame(32'h00AA, 16, 6);
        send_frame(32'h85FF, 16, 6);
        send_frame(32'h80F0 >> 1, 15, 6);
        send_frame((32'h81CC << 2) | 32'h3, 18, 6);
        send_frame(32'h8255, 16, 3);
        send_frame(32'h83AA, 16, 6);

        // ncs glitch with no clocks, then sclk activity while idle
        send_frame(32'h0, 0, 6);
        repeat (3) begin
            sclk = 1'b1;
            wait_clks(4);
            sclk = 1'b0;
            wait_clks(4);
        end
        send_frame(32'h8033, 16, 6);

        // Reset in the middle of a frame
        ncs = 1'b0;
        wait_clks(4);
        send_bits(32'h84, 8);
        rst_n = 1'b0;
        #2;
        for (int i = 0; i < 5; i++) m_regs[i] = 8'h00;
        check_regs("midrst");
        chk("midrst_strobe", 32'(wr_strobe), 32'd0);
        ncs  = 1'b1;
        sclk = 1'b0;
        wait_clks(3);
        rst_n = 1'b1;
        wait_clks(4);
        send_frame(32'h8411, 16, 6);

        // Randomised frames: mixed lengths, directions and addresses
        for (int k = 0; k < 25; k++) begin
            n    = int'($urandom_range(14, 18));
            base = {($urandom_range(0, 3) != 0), 7'($urandom_range(0, 7)), 8'($urandom)};
            v    = 32'(base);
            if (n > 16) v = (v << (n - 16)) | ($urandom & ((32'd1 << (n - 16)) - 1));
            if (n < 16) v = v >> (16 - n);
            send_frame(v, n, int'($urandom_range(3, 8)));
        end

        wait_clks(4);
        chk("strobe_total", 32'(strobe_cycles), 32'(exp_strobes));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_reg_ctrl.md
Name: spi_reg_ctrl

Overview:
SPI-mode-0 register controller that configures the PWM/output datapath of the top-level user project from an external host.
- Receives 16-bit write frames on sclk/copi/ncs, oversampled in the system clock domain.
- Commits valid writes into five 8-bit configuration registers that drive output enables, PWM enables and PWM duty cycle.
- Sits between the top-level ui_in pins and the PWM generator.

Parameters:
- MAX_ADDR, 4, highest valid register address; frames addressed above it are discarded.
- SYNC_STAGES, 2, flip-flop depth of the input synchronisers (minimum 2).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- sclk  in  1  SPI clock, asynchronous to clk
- copi  in  1  SPI data in, asynchronous
- ncs  in  1  SPI chip select, active-low, asynchronous
- en_reg_out_7_0  out  8  output enables, uo_out[7:0] (addr 0x00)
- en_reg_out_15_8  out  8  output enables, uio_out[7:0] (addr 0x01)
- en_reg_pwm_7_0  out  8  PWM enables, uo_out[7:0] (addr 0x02)
- en_reg_pwm_15_8  out  8  PWM enables, uio_out[7:0] (addr 0x03)
- pwm_duty_cycle  out  8  duty value, 0x00 = 0%, 0xFF = 100% (addr 0x04)
- wr_strobe  out  1  one-clk pulse on each committed write

Behaviour:
- Reset (rst_n low, asynchronous):
  - All five registers = 0x00 and wr_strobe = 0.
  - Bit counter = 0 and shift register = 0.
  - Synchroniser flops: sclk = 0, copi = 0, ncs = 1.
- Synchronisation:
  - sclk, copi and ncs each pass through SYNC_STAGES flops.
  - One further flop on sclk_s and on ncs_s feeds edge detection.
  - Host must hold sclk high and low for at least 3 clk periods each.
- Frame format, MSB first, 16 bits:
  - bit15 = R/W (1 = write).
  - bits14:8 = 7-bit address.
  - bits7:0 = data.
- State machine, two states:
  - IDLE: on ncs_s falling edge, clear counter and shift register, go to RECV.
  - RECV: on each sclk_s rising edge, shift copi_s into bit 0 and increment the counter. Sampling the synchronised copi on the detected edge is the chosen mode-0 sampling point.
  - RECV: the counter saturates at 16; further edges neither shift nor count.
  - RECV: on ncs_s rising edge, go to IDLE and evaluate the frame.
- Commit rule:
  - Commit requires all of: count == 16, bit15 == 1, addr <= MAX_ADDR.
  - When met, the register at addr takes data and wr_strobe pulses for exactly 1 cycle.
  - Otherwise nothing changes and no strobe is issued.
- Latency: the new register value is visible on the output after the clk edge SYNC_STAGES+1 edges after the first clk edge that samples ncs high. Default: 3 edges.
- Rejected cases:
  - Read frames (bit15 = 0): ignored. There is no CIPO; reads are unsupported.
  - Short frames (<16 bits): discarded.
  - Long frames (>16 bits): treated as the first 16 bits only.
- Edge cases:
  - sclk edges while in IDLE are ignored.
  - A glitch where ncs_s goes low then high with no sclk edges yields count 0, which is discarded.
  - Back-to-back frames with ncs high for 3 or more clk cycles are both committed.
  - rst_n asserted mid-frame aborts the frame and clears all registers. The first frame after deassertion must begin with a fresh ncs falling edge.
- Outputs are registered only; there are no combinational paths from inputs to outputs.

Decomposition:
- Shared package holds:
  - Register address constants: ADDR_EN_OUT_LO = 0x00, ADDR_EN_OUT_HI = 0x01, ADDR_EN_PWM_LO = 0x02, ADDR_EN_PWM_HI = 0x03, ADDR_DUTY = 0x04.
  - FRAME_BITS = 16.
  - The state enum {IDLE, RECV}.
- One sub-module, sync_edge: a SYNC_STAGES synchroniser plus rise/fall pulse outputs. It is instantiated for sclk and ncs; copi uses the synchroniser only.

Test Plan:
- Write frame 0x80F0 (write, addr 0x00, data 0xF0) -> en_reg_out_7_0 = 0xF0, one wr_strobe pulse, other registers still 0x00.
- Write 0x8480 -> pwm_duty_cycle = 0x80, visible exactly 3 clk edges after ncs is sampled high.
- Read frame 0x00AA, out-of-range address frame 0x85FF, and 15-bit frame 0x80F0 (last bit truncated) -> every register unchanged and no wr_strobe.
- 18-bit frame: 0x81CC followed by two extra 1 bits -> en_reg_out_15_8 = 0xCC.
- Back-to-back writes 0x8255 then 0x83AA with ncs high for 3 clk cycles between them -> en_reg_pwm_7_0 = 0x55, en_reg_pwm_15_8 = 0xAA, two wr_strobe pulses.
- Assert rst_n after bit 8 of frame 0x84FF, then send a full 0x8411 -> all registers 0x00 after reset, then duty = 0x11.
